// File: rtl/alu_cmd_issuer_pkg.sv
// alu_cmd_issuer_pkg
//   Shared definitions for the ALU command issuer slice:
//   - default datapath widths (operand and result)
//   - ALU opcode encodings OP_ADD .. OP_LXOR
//   - the issuer FSM state enum
package alu_cmd_issuer_pkg;

  localparam int NREG_DEFAULT = 4;
  localparam int DATA_W       = 8;
  localparam int RES_W        = 2 * DATA_W;
  localparam int OP_W         = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b010;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b011;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b100;
  localparam logic [OP_W-1:0] OP_LAND = 3'b101;
  localparam logic [OP_W-1:0] OP_LOR  = 3'b110;
  localparam logic [OP_W-1:0] OP_LXOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if
//   Command and response channels of the ALU command issuer.
//   Ports (as seen from the issuer, modport slave):
//     cmd_valid/cmd_ready   in/out  command handshake
//     cmd_op                in      ALU opcode
//     cmd_ra/cmd_rb/cmd_rd  in      source A, source B, destination register
//     rsp_valid/rsp_ready   out/in  response handshake
//     rsp_result/rsp_carry  out     captured 2*DW result and carry
//   modport master is the requester side (control logic or testbench).
interface alu_cmd_issuer_if #(
  parameter int NREG = 4,
  parameter int DW   = 8
);
  import alu_cmd_issuer_pkg::*;

  localparam int AW = $clog2(NREG);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [AW-1:0]   cmd_ra;
  logic [AW-1:0]   cmd_rb;
  logic [AW-1:0]   cmd_rd;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*DW-1:0] rsp_result;
  logic            rsp_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry
  );

endinterface

// File: rtl/alu_regfile.sv
// alu_regfile
//   NREG x DW operand register file for the ALU command issuer.
//   Ports:
//     clk, rst_n             clock, synchronous active-low reset (clears all registers)
//     rd_addr_a/rd_data_a    combinational read port A
//     rd_addr_b/rd_data_b    combinational read port B
//     ld_en/ld_addr/ld_data  external direct load port (lowest priority)
//     wb_en/wb_addr/wb_data  low-byte writeback port (highest priority)
//     hi_en/hi_addr/hi_data  high-byte writeback port (beats the load port)
module alu_regfile
  import alu_cmd_issuer_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int DW   = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREG)-1:0]  rd_addr_a,
  output logic [DW-1:0]            rd_data_a,
  input  logic [$clog2(NREG)-1:0]  rd_addr_b,
  output logic [DW-1:0]            rd_data_b,
  input  logic                     ld_en,
  input  logic [$clog2(NREG)-1:0]  ld_addr,
  input  logic [DW-1:0]            ld_data,
  input  logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [DW-1:0]            wb_data,
  input  logic                     hi_en,
  input  logic [$clog2(NREG)-1:0]  hi_addr,
  input  logic [DW-1:0]            hi_data
);

  localparam int AW = $clog2(NREG);

  logic [DW-1:0] regs [NREG];

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  // Per-register write arbitration: ALU writebacks always beat an external
  // load aimed at the same register, while loads to other registers still land.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          regs[i] <= wb_data;
        end else if (hi_en && (hi_addr == AW'(i))) begin
          regs[i] <= hi_data;
        end else if (ld_en && (ld_addr == AW'(i))) begin
          regs[i] <= ld_data;
        end
      end
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Command-side sequencer for the 8-bit combinational ALU. Accepts a command,
//   snapshots its operands from the local register file, drives the ALU for one
//   cycle, captures result/carry, writes the low byte back to rd and returns the
//   result on the response channel.
//   Ports:
//     clk, rst_n              clock, synchronous active-low reset
//     bus (slave)             command / response channels (alu_cmd_issuer_if)
//     wr_en/wr_addr/wr_data   direct register load, honoured in every state
//     alu_a/alu_b/alu_opcode  operands and opcode to the ALU (hold last value)
//     alu_result/alu_carry    combinational ALU result and carry/borrow
//   Build option:
//     ALU_CMD_ISSUER_WB_HI_EN  when defined, a mul also writes the high result
//                              byte to register (rd+1) mod NREG.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int DW   = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_cmd_issuer_if.slave          bus,
  input  logic                     wr_en,
  input  logic [$clog2(NREG)-1:0]  wr_addr,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [OP_W-1:0]          alu_opcode,
  input  logic [2*DW-1:0]          alu_result,
  input  logic                     alu_carry
);

  localparam int AW = $clog2(NREG);

  state_t          state;
  state_t          state_nxt;

  logic [OP_W-1:0] op_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [AW-1:0]   rd_q;
  logic [2*DW-1:0] result_q;
  logic            carry_q;

  logic [DW-1:0]   rf_a;
  logic [DW-1:0]   rf_b;
  logic            accept;
  logic            in_issue;
  logic            wb_hi_en;
  logic [AW-1:0]   rd_hi;

  // cmd_ready is gated by rst_n so it reads 0 while reset is held.
  assign bus.cmd_ready  = rst_n && (state == ST_IDLE);
  assign accept         = bus.cmd_valid && bus.cmd_ready;
  assign in_issue       = (state == ST_ISSUE);

  assign bus.rsp_valid  = (state == ST_RESP);
  assign bus.rsp_result = result_q;
  assign bus.rsp_carry  = carry_q;

  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_opcode     = op_q;

  // NREG is a power of two, so the natural wrap of the adder gives mod NREG.
  assign rd_hi          = rd_q + AW'(1);

`ifdef ALU_CMD_ISSUER_WB_HI_EN
  assign wb_hi_en = in_issue && (op_q == OP_MUL);
`else
  assign wb_hi_en = 1'b0;
`endif

  alu_regfile #(
    .NREG (NREG),
    .DW   (DW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (bus.cmd_ra),
    .rd_data_a (rf_a),
    .rd_addr_b (bus.cmd_rb),
    .rd_data_b (rf_b),
    .ld_en     (wr_en),
    .ld_addr   (wr_addr),
    .ld_data   (wr_data),
    .wb_en     (in_issue),
    .wb_addr   (rd_q),
    .wb_data   (alu_result[DW-1:0]),
    .hi_en     (wb_hi_en),
    .hi_addr   (rd_hi),
    .hi_data   (alu_result[2*DW-1:DW])
  );

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: ISSUE always lasts a single cycle, RESP waits for rsp_ready
  // and never overlaps with accepting the next command.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Operand snapshot at accept (later loads cannot disturb the in-flight op)
  // and result capture at the end of ISSUE, held until the next ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.cmd_op;
        a_q  <= rf_a;
        b_q  <= rf_b;
        rd_q <= bus.cmd_rd;
      end
      if (in_issue) begin
        result_q <= alu_result;
        carry_q  <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer
//   Self-checking bench for alu_cmd_issuer. Provides a behavioural ALU, keeps
//   its own register-file model and checks handshake timing, operand snapshot,
//   response payload, writeback priority, throughput and mid-operation reset.
module tb_alu_cmd_issuer;
  import alu_cmd_issuer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_carry;

  int vectors     = 0;
  int miscompares = 0;
  int ref_regs [4];
  int cyc         = 0;
  int last_accept = -1;
  bit gap_mode    = 1'b0;

  alu_cmd_issuer_if #(.NREG(4), .DW(8)) bus ();

  alu_cmd_issuer #(.NREG(4), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_carry  (alu_carry)
  );

  // Free-running clock and a cycle counter used to measure accept spacing.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {carry, 16-bit result}.
  function automatic logic [16:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    int  ai;
    int  bi;
    int  r;
    logic c;
    ai = int'(a);
    bi = int'(b);
    r  = 0;
    c  = 1'b0;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 255); end
      3'd1: begin r = (ai - bi) & 32'hFFFF; c = (ai < bi); end
      3'd2: r = ai * bi;
      3'd3: begin r = ai << (bi % 8); c = ((r >> 8) & 1) == 1; end
      3'd4: r = ai >> (bi % 8);
      3'd5: r = ai & bi;
      3'd6: r = ai | bi;
      default: r = ai ^ bi;
    endcase
    return {c, 16'(r & 32'hFFFF)};
  endfunction

  assign {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_opcode);

  // Single comparison point: counts vectors and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Direct register load for one cycle; updates the model afterwards.
  task automatic loadReg(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = addr[1:0];
    wr_data = data[7:0];
    @(negedge clk);
    wr_en = 1'b0;
    ref_regs[addr] = data & 255;
  endtask

  // One full command: wait for ready, check ISSUE operands, optional load in
  // the ISSUE cycle, check the response and stall it for 'hold' cycles.
  // Returns at a RESP negedge with rsp_ready already high.
  task automatic applyStimulus(input int op, input int ra, input int rb, input int rd,
                               input int hold, input bit keep, input bit coll,
                               input int ld_addr, input int ld_data);
    logic [16:0] exp;
    int guard;
    int a;
    int b;
    bus.cmd_op    = op[2:0];
    bus.cmd_ra    = ra[1:0];
    bus.cmd_rb    = rb[1:0];
    bus.cmd_rd    = rd[1:0];
    bus.cmd_valid = 1'b1;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("cmd_ready_at_accept", 32'(bus.cmd_ready), 32'(1));
    checkOutput("rsp_valid_idle", 32'(bus.rsp_valid), 32'(0));
    if (gap_mode && last_accept >= 0) checkOutput("accept_spacing", cyc - last_accept, 32'(3));
    last_accept = cyc;
    a   = ref_regs[ra];
    b   = ref_regs[rb];
    exp = alu_fn(a[7:0], b[7:0], op[2:0]);

    @(negedge clk);
    if (!keep) bus.cmd_valid = 1'b0;
    checkOutput("issue_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    checkOutput("issue_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    checkOutput("issue_alu_a", 32'(alu_a), a);
    checkOutput("issue_alu_b", 32'(alu_b), b);
    checkOutput("issue_alu_op", 32'(alu_opcode), op);
    if (coll) begin
      wr_en   = 1'b1;
      wr_addr = ld_addr[1:0];
      wr_data = ld_data[7:0];
    end
    bus.rsp_ready = (hold == 0);

    @(negedge clk);
    wr_en = 1'b0;
    if (coll) ref_regs[ld_addr] = ld_data & 255;
    ref_regs[rd] = int'(exp[7:0]);
`ifdef ALU_CMD_ISSUER_WB_HI_EN
    if (op == 2) ref_regs[(rd + 1) % 4] = int'(exp[15:8]);
`endif
    checkOutput("resp_valid", 32'(bus.rsp_valid), 32'(1));
    checkOutput("resp_result", 32'(bus.rsp_result), 32'(exp[15:0]));
    checkOutput("resp_carry", 32'(bus.rsp_carry), 32'(exp[16]));
    checkOutput("resp_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(bus.rsp_valid), 32'(1));
      checkOutput("hold_result", 32'(bus.rsp_result), 32'(exp[15:0]));
      checkOutput("hold_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    end
    bus.rsp_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_ra    = '0;
    bus.cmd_rb    = '0;
    bus.cmd_rd    = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 0;

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    checkOutput("rst_rsp_result", 32'(bus.rsp_result), 32'(0));
    checkOutput("rst_rsp_carry", 32'(bus.rsp_carry), 32'(0));
    checkOutput("rst_alu_a", 32'(alu_a), 32'(0));
    checkOutput("rst_alu_b", 32'(alu_b), 32'(0));
    checkOutput("rst_alu_op", 32'(alu_opcode), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));

    // Add with carry out, then read r2 back through a command.
    $display("[TB] add 0xC8 + 0x64");
    loadReg(0, 8'hC8);
    loadReg(1, 8'h64);
    applyStimulus(0, 0, 1, 2, 0, 1'b0, 1'b0, 0, 0);
    checkOutput("add_const_result", 32'(bus.rsp_result), 32'h012C);
    checkOutput("add_const_carry", 32'(bus.rsp_carry), 32'(1));
    applyStimulus(6, 2, 2, 3, 0, 1'b0, 1'b0, 0, 0);
    checkOutput("r2_readback", 32'(alu_a), 32'h2C);

    // Multiply, then read r3 and r0 (r0 changes only with the high-byte option).
    $display("[TB] mul 0x0F * 0x11");
    loadReg(0, 8'h0F);
    loadReg(1, 8'h11);
    applyStimulus(2, 0, 1, 3, 0, 1'b0, 1'b0, 0, 0);
    checkOutput("mul_const_result", 32'(bus.rsp_result), 32'h00FF);
    applyStimulus(0, 3, 0, 1, 0, 1'b0, 1'b0, 0, 0);
    checkOutput("r3_readback", 32'(alu_a), 32'hFF);

    // Subtract with the response stalled for 5 cycles.
    $display("[TB] sub with stalled response");
    loadReg(0, 8'h05);
    loadReg(1, 8'h03);
    applyStimulus(1, 0, 1, 2, 5, 1'b0, 1'b0, 0, 0);
    checkOutput("sub_const_result", 32'(bus.rsp_result), 32'h0002);

    // Same-cycle load vs writeback: same register, then a different register.
    $display("[TB] load/writeback collisions");
    loadReg(0, 8'h10);
    loadReg(1, 8'h01);
    applyStimulus(0, 0, 1, 2, 0, 1'b0, 1'b1, 2, 8'hAA);
    applyStimulus(0, 0, 1, 2, 0, 1'b0, 1'b1, 1, 8'h77);
    applyStimulus(7, 2, 1, 3, 0, 1'b0, 1'b0, 0, 0);
    checkOutput("collision_r2", 32'(alu_a), 32'h11);
    checkOutput("collision_r1", 32'(alu_b), 32'h77);

    // Back-to-back commands with cmd_valid held high and rsp_ready high.
    $display("[TB] back-to-back throughput");
    gap_mode    = 1'b1;
    last_accept = -1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    0, 1'b1, 1'b0, 0, 0);
    end
    bus.cmd_valid = 1'b0;
    gap_mode      = 1'b0;

    // Randomized commands with interleaved loads, stalls and collisions.
    $display("[TB] randomized commands");
    for (int k = 0; k < 25; k++) begin
      int nld;
      nld = int'($urandom_range(0, 2));
      for (int j = 0; j < nld; j++) begin
        loadReg(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      end
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end

    // Reset asserted while in RESP: everything returns to reset values.
    $display("[TB] reset during response");
    loadReg(0, 8'h33);
    loadReg(1, 8'h44);
    applyStimulus(0, 0, 1, 2, 2, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) ref_regs[i] = 0;
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    checkOutput("midrst_rsp_result", 32'(bus.rsp_result), 32'(0));
    checkOutput("midrst_rsp_carry", 32'(bus.rsp_carry), 32'(0));
    checkOutput("midrst_alu_a", 32'(alu_a), 32'(0));
    checkOutput("midrst_alu_op", 32'(alu_opcode), 32'(0));
    checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_release_ready", 32'(bus.cmd_ready), 32'(1));
    applyStimulus(0, 0, 1, 2, 0, 1'b0, 1'b0, 0, 0);
    checkOutput("post_rst_add", 32'(bus.rsp_result), 32'h0000);
    @(negedge clk);
    checkOutput("final_idle_valid", 32'(bus.rsp_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side sequencer that drives the 8-bit ALU datapath. It accepts operation commands over a valid/ready handshake and reads operands from a small local register file. It presents opcode and operands to the combinational ALU, captures the 16-bit result and carry, writes the low byte back, and returns the result on a valid/ready response channel. It sits between the control logic issuing arithmetic/logic requests and the ALU.

## Interface
- `NREG`, 4: number of 8-bit operand registers; power of two, address width `$clog2(NREG)`.
- `DW`, 8: operand width; result width is `2*DW`.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: issuer can accept a command.
- `cmd_op` in 3: ALU opcode (000 add, 001 sub, 010 mul, 011 shl, 100 shr, 101 land, 110 lor, 111 lxor).
- `cmd_ra`, `cmd_rb`, `cmd_rd` in log2(NREG) each: source A, source B, destination register.
- `wr_en` in 1: direct register load strobe.
- `wr_addr` in log2(NREG): load address.
- `wr_data` in DW: load data.
- `alu_a`, `alu_b` out DW: operands to ALU.
- `alu_opcode` out 3: opcode to ALU.
- `alu_result` in 2*DW: ALU result, combinational from `alu_*` outputs.
- `alu_carry` in 1: ALU carry/borrow.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_result` out 2*DW: captured ALU result.
- `rsp_carry` out 1: captured carry.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: `cmd_ready`=1. When `cmd_valid` is high, the issuer latches op, the values of registers ra and rb, and rd, then moves to ISSUE.
- ISSUE (exactly one cycle): `alu_a`/`alu_b`/`alu_opcode` are driven from the latched values. At the end of the cycle, `alu_result`/`alu_carry` are captured into `rsp_result`/`rsp_carry`, `reg[rd] <= alu_result[DW-1:0]`, and the FSM goes to RESP.
- RESP: `rsp_valid`=1 with the payload held stable. When `rsp_ready` is high, the FSM goes to IDLE. No new command is taken in the same cycle.
- Operands are snapshotted at accept, so `wr_en` loads after accept do not affect the in-flight op.
- `wr_en` is honoured in every state.
- If a `wr_en` load and the ISSUE writeback hit the same register in the same cycle, the writeback wins. Loads to different registers both take effect.
- ra, rb and rd may alias one another (e.g. `r0 = r0 + r0`). Reads use pre-writeback values.
- Outside ISSUE, `alu_a`, `alu_b` and `alu_opcode` hold their last latched values; they are not zeroed.
- Arithmetic is performed entirely by the ALU. The issuer passes the full `2*DW` result and carry unmodified to the response.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after reset. `rsp_valid`=0, `rsp_result`=0, `rsp_carry`=0, `alu_a`=`alu_b`=0, `alu_opcode`=000, all registers 0, FSM in IDLE.
- Latency: command accepted at edge N, ALU driven during cycle N+1, `rsp_valid` high from cycle N+2.
- Throughput: at most one command per 3 cycles with `rsp_ready` tied high.
- Register file effect: the writeback is visible to a command accepted at or after the edge that ends ISSUE.
- `rsp_ready` low: `rsp_valid` and the payload are held indefinitely and `cmd_ready` stays 0.
- Reset mid-operation (ISSUE or RESP): the in-flight op is dropped, no writeback occurs, and all state returns to reset values on that edge.

## Configuration
- `ALU_CMD_ISSUER_WB_HI_EN` defined: for `cmd_op`=010 (mul), ISSUE additionally writes `alu_result[2*DW-1:DW]` to register `(rd+1) mod NREG`. This write also takes priority over a same-cycle `wr_en` to that register.
- `ALU_CMD_ISSUER_WB_HI_EN` undefined: only the low byte is written for every opcode. The high byte is available only on `rsp_result`.

## Structure
- The shared package holds the opcode localparams (`OP_ADD` … `OP_LXOR`), the FSM state enum, and `DW`/result-width constants.
- Sub-module `alu_regfile` provides NREG×DW storage, two combinational read ports, a load port, and a priority writeback port (plus the optional high write port).
- The FSM, operand latches and response register live in the top level.

## Test plan
- Load r0=0xC8, r1=0x64, command add ra=0 rb=1 rd=2 -> `rsp_result`=0x012C two cycles after accept, and r2 reads 0x2C.
- Command mul with r0=0x0F, r1=0x11, rd=3 -> `rsp_result`=0x00FF and r3=0xFF. With `ALU_CMD_ISSUER_WB_HI_EN` defined, r0 becomes 0x00 (wrap from 3 to 0).
- Hold `rsp_ready`=0 for 5 cycles after a sub of 0x05−0x03 -> `rsp_valid` stays high, `rsp_result`=0x0002 stable, `cmd_ready`=0 throughout.
- Issue `wr_en` to r2=0xAA in the same cycle as the ISSUE writeback to r2 of 0x11 -> r2=0x11. A load to r1 in the same cycle also takes effect.
- Deassert `rst_n` during RESP -> next cycle `rsp_valid`=0 and all registers 0; a fresh add of r0+r1 returns 0x0000.
- Send back-to-back `cmd_valid` with `rsp_ready`=1 -> accepts spaced exactly 3 cycles apart, with no command dropped or duplicated.
